// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: requester index, FSM states and
// the wrap-around increment used by the round-robin pointers.
package sram_port_arbiter_pkg;

  localparam int PKG_NUM_REQUESTERS = 4;
  localparam int PKG_ID_WIDTH       = $clog2(PKG_NUM_REQUESTERS);

  typedef logic [PKG_ID_WIDTH-1:0] req_id_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  // Explicit wrap so the requester count need not be a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Client-facing bus of the SRAM port arbiter: per-client read/write request
// lanes, grants, the read response and the init flag.
interface sram_port_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int ID_WIDTH       = 2
);
  logic [NUM_REQUESTERS-1:0]                 rd_req;
  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_REQUESTERS-1:0]                 rd_grant;
  logic                                      rd_resp_valid;
  logic [ID_WIDTH-1:0]                       rd_resp_id;
  logic [DATA_WIDTH-1:0]                     rd_resp_data;
  logic [NUM_REQUESTERS-1:0]                 wr_req;
  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] wr_data;
  logic [NUM_REQUESTERS-1:0]                 wr_grant;
  logic                                      init_done;

  // Client side.
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_grant, rd_resp_valid, rd_resp_id, rd_resp_data, wr_grant, init_done
  );

  // Arbiter side.
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_grant, rd_resp_valid, rd_resp_id, rd_resp_data, wr_grant, init_done
  );
endinterface

// File: rtl/sram_1r1w.sv
// Simple one-read one-write synchronous SRAM. Registered read data; no reset
// on the array. Optional bypass returns the write data on a same-address
// read in the same cycle.
module sram_1r1w #(
  parameter int    DATA_WIDTH        = 32,
  parameter int    SIZE              = 1024,
  parameter int    ADDR_WIDTH        = $clog2(SIZE),
  parameter string READ_DURING_WRITE = "NEW_DATA"
) (
  input  logic                  clk,
  input  logic                  i_read_en,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  output logic [DATA_WIDTH-1:0] o_read_data,
  input  logic                  i_write_en,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data
);
  localparam bit NEW_DATA = (READ_DURING_WRITE == "NEW_DATA");

  logic [DATA_WIDTH-1:0] r_mem [SIZE];
  logic [DATA_WIDTH-1:0] r_read_data;

  // Array write; addresses beyond SIZE are ignored (SIZE may be non-pow2).
  always_ff @(posedge clk) begin
    if (i_write_en && (int'(i_write_addr) < SIZE))
      r_mem[i_write_addr] <= i_write_data;
  end

  // Registered read with optional write-to-read bypass.
  always_ff @(posedge clk) begin
    if (i_read_en) begin
      if (NEW_DATA && i_write_en && (i_write_addr == i_read_addr))
        r_read_data <= i_write_data;
      else if (int'(i_read_addr) < SIZE)
        r_read_data <= r_mem[i_read_addr];
      else
        r_read_data <= '0;
    end
  end

  assign o_read_data = r_read_data;
endmodule

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans upward from its pointer with explicit wrap,
// grants the first active request, and moves the pointer past the winner.
module rr_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] i_req,
  input  logic                      i_en,
  output logic [NUM_REQUESTERS-1:0] o_grant,
  output logic [ID_WIDTH-1:0]       o_grant_idx,
  output logic                      o_grant_vld
);
  logic [ID_WIDTH-1:0]       r_ptr;
  logic [NUM_REQUESTERS-1:0] w_grant;
  logic [ID_WIDTH-1:0]       w_idx;
  logic                      w_found;

  // Pick the first requester at or after the pointer, wrapping N-1 -> 0.
  always_comb begin
    int k;
    k       = 0;
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      k = int'(r_ptr) + i;
      if (k >= NUM_REQUESTERS) k = k - NUM_REQUESTERS;
      if (i_en && !w_found && i_req[k]) begin
        w_found    = 1'b1;
        w_grant[k] = 1'b1;
        w_idx      = ID_WIDTH'(k);
      end
    end
  end

  // Pointer advances past the winner; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_ptr <= '0;
    else if (w_found)
      r_ptr <= ID_WIDTH'(rr_next(int'(w_idx), NUM_REQUESTERS));
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;
  assign o_grant_vld = w_found;
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1R1W SRAM between several clients with independent round-robin
// arbitration per port. Zero-fills the array after reset before granting.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 1024,
  parameter int ADDR_WIDTH     = $clog2(SIZE),
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sram_port_arbiter_if.slave   io_bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

  arb_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_clear_addr;
  logic                  r_rd_resp_valid;
  logic [ID_WIDTH-1:0]   r_rd_resp_id;

  logic                      w_run;
  logic [NUM_REQUESTERS-1:0] w_rd_grant, w_wr_grant;
  logic [ID_WIDTH-1:0]       w_rd_idx, w_wr_idx;
  logic                      w_rd_vld, w_wr_vld;

  logic                  w_sram_rd_en;
  logic [ADDR_WIDTH-1:0] w_sram_rd_addr;
  logic [DATA_WIDTH-1:0] w_sram_rd_data;
  logic                  w_sram_wr_en;
  logic [ADDR_WIDTH-1:0] w_sram_wr_addr;
  logic [DATA_WIDTH-1:0] w_sram_wr_data;

  assign w_run = (r_state == ST_RUN);

  rr_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .ID_WIDTH       (ID_WIDTH)
  ) u_rd_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (io_bus.rd_req),
    .i_en        (w_run),
    .o_grant     (w_rd_grant),
    .o_grant_idx (w_rd_idx),
    .o_grant_vld (w_rd_vld)
  );

  rr_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .ID_WIDTH       (ID_WIDTH)
  ) u_wr_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (io_bus.wr_req),
    .i_en        (w_run),
    .o_grant     (w_wr_grant),
    .o_grant_idx (w_wr_idx),
    .o_grant_vld (w_wr_vld)
  );

  // Clear FSM: walk clear_addr over the whole array, then settle in RUN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clear_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clear_addr == LAST_ADDR)
        r_state <= ST_RUN;
      else
        r_clear_addr <= r_clear_addr + 1'b1;
    end
  end

  // Read response tracking; a response in flight across reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_resp_valid <= 1'b0;
      r_rd_resp_id    <= '0;
    end else begin
      r_rd_resp_valid <= w_rd_vld;
      if (w_rd_vld) r_rd_resp_id <= w_rd_idx;
    end
  end

  // Write port mux: clear traffic owns the port outside RUN.
  always_comb begin
    w_sram_wr_en   = 1'b0;
    w_sram_wr_addr = '0;
    w_sram_wr_data = '0;
    if (r_state == ST_CLEAR) begin
      w_sram_wr_en   = 1'b1;
      w_sram_wr_addr = r_clear_addr;
    end else if (w_wr_vld) begin
      w_sram_wr_en   = 1'b1;
      w_sram_wr_addr = io_bus.wr_addr[w_wr_idx];
      w_sram_wr_data = io_bus.wr_data[w_wr_idx];
    end
  end

  // Read port mux: the granted client's address.
  always_comb begin
    w_sram_rd_en   = w_rd_vld;
    w_sram_rd_addr = io_bus.rd_addr[w_rd_idx];
  end

  sram_1r1w #(
    .DATA_WIDTH        (DATA_WIDTH),
    .SIZE              (SIZE),
    .ADDR_WIDTH        (ADDR_WIDTH),
    .READ_DURING_WRITE ("NEW_DATA")
  ) u_sram (
    .clk          (clk),
    .i_read_en    (w_sram_rd_en),
    .i_read_addr  (w_sram_rd_addr),
    .o_read_data  (w_sram_rd_data),
    .i_write_en   (w_sram_wr_en),
    .i_write_addr (w_sram_wr_addr),
    .i_write_data (w_sram_wr_data)
  );

  assign io_bus.rd_grant      = w_rd_grant;
  assign io_bus.wr_grant      = w_wr_grant;
  assign io_bus.rd_resp_valid = r_rd_resp_valid;
  assign io_bus.rd_resp_id    = r_rd_resp_id;
  assign io_bus.rd_resp_data  = w_sram_rd_data;
  assign io_bus.init_done     = w_run & reset_n;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one instance with zero-fill
// (SIZE=16) and one starting directly in RUN.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SZ = 16;
  localparam int AW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic reset_b_n;
  int   n_cmp = 0;
  int   n_err = 0;

  sram_port_arbiter_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus_a ();
  sram_port_arbiter_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus_b ();

  sram_port_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW),
                      .ID_WIDTH(IW), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .io_bus(bus_a));

  sram_port_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW),
                      .ID_WIDTH(IW), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_b_n), .io_bus(bus_b));

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reset_b_n = 1'b0;
    bus_a.rd_req = '0; bus_a.wr_req = '0; bus_a.rd_addr = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.rd_req = '0; bus_b.wr_req = '0; bus_b.rd_addr = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    repeat (3) next_cycle();
    #2;
    n_cmp++; if (bus_a.rd_grant !== 4'b0000) begin n_err++; $display("FAIL rst_rd_grant: got %b want 0000", bus_a.rd_grant); end
    n_cmp++; if (bus_a.wr_grant !== 4'b0000) begin n_err++; $display("FAIL rst_wr_grant: got %b want 0000", bus_a.wr_grant); end
    n_cmp++; if (bus_a.rd_resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", bus_a.rd_resp_valid); end
    n_cmp++; if (bus_a.rd_resp_id !== 2'd0) begin n_err++; $display("FAIL rst_resp_id: got %0d want 0", bus_a.rd_resp_id); end
    n_cmp++; if (bus_a.init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done: got %b want 0", bus_a.init_done); end
    n_cmp++; if (bus_b.init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done_b: got %b want 0", bus_b.init_done); end
    n_cmp++; if (dut_a.u_rd_arb.r_ptr !== 2'd0) begin n_err++; $display("FAIL rst_rd_ptr: got %0d want 0", dut_a.u_rd_arb.r_ptr); end
  endtask

  // All clients request throughout CLEAR; nobody is granted until cycle 16.
  task automatic test_clear();
    next_cycle();
    reset_n = 1'b1;
    bus_a.rd_req = 4'b1111;
    for (int c = 0; c < SZ; c++) begin
      #2;
      n_cmp++; if (bus_a.init_done !== 1'b0) begin n_err++; $display("FAIL clr_init_done c=%0d: got %b want 0", c, bus_a.init_done); end
      n_cmp++; if (bus_a.rd_grant !== 4'b0000) begin n_err++; $display("FAIL clr_rd_grant c=%0d: got %b want 0000", c, bus_a.rd_grant); end
      next_cycle();
    end
    #2;
    n_cmp++; if (bus_a.init_done !== 1'b1) begin n_err++; $display("FAIL clr_init_rise: got %b want 1", bus_a.init_done); end
    n_cmp++; if (bus_a.rd_grant !== 4'b0001) begin n_err++; $display("FAIL clr_first_grant: got %b want 0001", bus_a.rd_grant); end
  endtask

  // Client 0 reads every address back to back; all must be zero.
  task automatic test_read_all();
    for (int a = 0; a <= SZ; a++) begin
      next_cycle();
      if (a < SZ) begin bus_a.rd_req = 4'b0001; bus_a.rd_addr[0] = AW'(a); end
      else bus_a.rd_req = 4'b0000;
      #2;
      if (a < SZ) begin
        n_cmp++; if (bus_a.rd_grant !== 4'b0001) begin n_err++; $display("FAIL rdall_grant a=%0d: got %b want 0001", a, bus_a.rd_grant); end
      end
      n_cmp++; if (bus_a.rd_resp_valid !== 1'b1) begin n_err++; $display("FAIL rdall_valid a=%0d: got %b want 1", a, bus_a.rd_resp_valid); end
      n_cmp++; if (bus_a.rd_resp_id !== 2'd0) begin n_err++; $display("FAIL rdall_id a=%0d: got %0d want 0", a, bus_a.rd_resp_id); end
      n_cmp++; if (bus_a.rd_resp_data !== 32'h0) begin n_err++; $display("FAIL rdall_data a=%0d: got %h want 0", a, bus_a.rd_resp_data); end
    end
    next_cycle();
    #2;
    n_cmp++; if (bus_a.rd_resp_valid !== 1'b0) begin n_err++; $display("FAIL rdall_idle: got %b want 0", bus_a.rd_resp_valid); end
  endtask

  // Pointer is 1 here; continuous requests rotate 1,2,3,0,1,...
  task automatic test_fairness();
    req_id_t exp_id;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      bus_a.rd_req = 4'b1111;
      #2;
      n_cmp++; if (bus_a.rd_grant !== 4'(1 << ((1 + k) % 4))) begin n_err++; $display("FAIL rr_grant k=%0d: got %b want %b", k, bus_a.rd_grant, 4'(1 << ((1 + k) % 4))); end
      if (k > 0) begin
        exp_id = req_id_t'(k % 4);
        n_cmp++; if (bus_a.rd_resp_id !== exp_id || bus_a.rd_resp_valid !== 1'b1) begin n_err++; $display("FAIL rr_resp k=%0d: got v=%b id=%0d want v=1 id=%0d", k, bus_a.rd_resp_valid, bus_a.rd_resp_id, exp_id); end
      end
    end
    next_cycle();
    bus_a.rd_req = 4'b0000;
    #2;
    n_cmp++; if (bus_a.rd_resp_id !== 2'd0 || bus_a.rd_resp_valid !== 1'b1) begin n_err++; $display("FAIL rr_resp_last: got v=%b id=%0d want v=1 id=0", bus_a.rd_resp_valid, bus_a.rd_resp_id); end
  endtask

  // From pointer 1: {1,3} -> 1 (ptr 2), {3} -> 3 (ptr 0), {1} -> 1 (ptr 2).
  task automatic test_pointer();
    next_cycle(); bus_a.rd_req = 4'b1010; #2;
    n_cmp++; if (bus_a.rd_grant !== 4'b0010) begin n_err++; $display("FAIL ptr_g1: got %b want 0010", bus_a.rd_grant); end
    next_cycle(); bus_a.rd_req = 4'b1000; #2;
    n_cmp++; if (dut_a.u_rd_arb.r_ptr !== 2'd2) begin n_err++; $display("FAIL ptr_p1: got %0d want 2", dut_a.u_rd_arb.r_ptr); end
    n_cmp++; if (bus_a.rd_grant !== 4'b1000) begin n_err++; $display("FAIL ptr_g2: got %b want 1000", bus_a.rd_grant); end
    next_cycle(); bus_a.rd_req = 4'b0010; #2;
    n_cmp++; if (dut_a.u_rd_arb.r_ptr !== 2'd0) begin n_err++; $display("FAIL ptr_p2: got %0d want 0", dut_a.u_rd_arb.r_ptr); end
    n_cmp++; if (bus_a.rd_grant !== 4'b0010) begin n_err++; $display("FAIL ptr_g3: got %b want 0010", bus_a.rd_grant); end
    next_cycle(); bus_a.rd_req = 4'b0000; #2;
    n_cmp++; if (dut_a.u_rd_arb.r_ptr !== 2'd2) begin n_err++; $display("FAIL ptr_p3: got %0d want 2", dut_a.u_rd_arb.r_ptr); end
  endtask

  // Client 0 writes addr 5 while client 2 reads addr 5 in the same cycle.
  task automatic test_read_during_write();
    next_cycle();
    bus_a.wr_req = 4'b0001; bus_a.wr_addr[0] = 4'd5; bus_a.wr_data[0] = 32'hDEADBEEF;
    bus_a.rd_req = 4'b0100; bus_a.rd_addr[2] = 4'd5;
    #2;
    n_cmp++; if (bus_a.wr_grant !== 4'b0001) begin n_err++; $display("FAIL rdw_wr_grant: got %b want 0001", bus_a.wr_grant); end
    n_cmp++; if (bus_a.rd_grant !== 4'b0100) begin n_err++; $display("FAIL rdw_rd_grant: got %b want 0100", bus_a.rd_grant); end
    next_cycle();
    bus_a.wr_req = 4'b0000; bus_a.rd_req = 4'b0010; bus_a.rd_addr[1] = 4'd5;
    #2;
    n_cmp++; if (bus_a.rd_resp_valid !== 1'b1 || bus_a.rd_resp_id !== 2'd2) begin n_err++; $display("FAIL rdw_resp: got v=%b id=%0d want v=1 id=2", bus_a.rd_resp_valid, bus_a.rd_resp_id); end
    n_cmp++; if (bus_a.rd_resp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rdw_data: got %h want deadbeef", bus_a.rd_resp_data); end
    n_cmp++; if (bus_a.rd_grant !== 4'b0010) begin n_err++; $display("FAIL rdw_rd_grant2: got %b want 0010", bus_a.rd_grant); end
    next_cycle();
    bus_a.rd_req = 4'b0000;
    #2;
    n_cmp++; if (bus_a.rd_resp_data !== 32'hDEADBEEF || bus_a.rd_resp_id !== 2'd1) begin n_err++; $display("FAIL rdw_stored: got id=%0d %h want id=1 deadbeef", bus_a.rd_resp_id, bus_a.rd_resp_data); end
  endtask

  // Write pointer 1: {0,3} -> 3 then 0; reads overlap writes every cycle.
  task automatic test_back_to_back();
    next_cycle();
    bus_a.wr_req = 4'b1001;
    bus_a.wr_addr[3] = 4'd7; bus_a.wr_data[3] = 32'h11111111;
    bus_a.wr_addr[0] = 4'd8; bus_a.wr_data[0] = 32'h22222222;
    #2;
    n_cmp++; if (bus_a.wr_grant !== 4'b1000) begin n_err++; $display("FAIL b2b_wg1: got %b want 1000", bus_a.wr_grant); end
    next_cycle();
    bus_a.wr_req = 4'b0001; bus_a.rd_req = 4'b0010; bus_a.rd_addr[1] = 4'd7;
    #2;
    n_cmp++; if (bus_a.wr_grant !== 4'b0001) begin n_err++; $display("FAIL b2b_wg2: got %b want 0001", bus_a.wr_grant); end
    n_cmp++; if (bus_a.rd_grant !== 4'b0010) begin n_err++; $display("FAIL b2b_rg1: got %b want 0010", bus_a.rd_grant); end
    next_cycle();
    bus_a.wr_req = 4'b0000; bus_a.rd_addr[1] = 4'd8;
    #2;
    n_cmp++; if (bus_a.rd_resp_valid !== 1'b1 || bus_a.rd_resp_data !== 32'h11111111) begin n_err++; $display("FAIL b2b_d7: got v=%b %h want v=1 11111111", bus_a.rd_resp_valid, bus_a.rd_resp_data); end
    n_cmp++; if (bus_a.rd_grant !== 4'b0010) begin n_err++; $display("FAIL b2b_rg2: got %b want 0010", bus_a.rd_grant); end
    next_cycle();
    bus_a.rd_req = 4'b0000;
    #2;
    n_cmp++; if (bus_a.rd_resp_valid !== 1'b1 || bus_a.rd_resp_data !== 32'h22222222) begin n_err++; $display("FAIL b2b_d8: got v=%b %h want v=1 22222222", bus_a.rd_resp_valid, bus_a.rd_resp_data); end
  endtask

  // Reset lands in the cycle client 2 is granted; the response must vanish,
  // the clear reruns and earlier writes read back as zero.
  task automatic test_reset_mid();
    logic [AW-1:0] addrs [3];
    addrs[0] = 4'd5; addrs[1] = 4'd7; addrs[2] = 4'd8;
    next_cycle();
    bus_a.rd_req = 4'b0100; bus_a.rd_addr[2] = 4'd5; reset_n = 1'b0;
    #2;
    n_cmp++; if (bus_a.rd_grant !== 4'b0100) begin n_err++; $display("FAIL mid_grant: got %b want 0100", bus_a.rd_grant); end
    next_cycle();
    reset_n = 1'b1; bus_a.rd_req = 4'b0000;
    #2;
    n_cmp++; if (bus_a.rd_resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_dropped: got %b want 0", bus_a.rd_resp_valid); end
    n_cmp++; if (dut_a.u_rd_arb.r_ptr !== 2'd0) begin n_err++; $display("FAIL mid_ptr: got %0d want 0", dut_a.u_rd_arb.r_ptr); end
    for (int c = 1; c < SZ; c++) begin
      next_cycle(); #2;
      n_cmp++; if (bus_a.init_done !== 1'b0 || bus_a.rd_resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_clear c=%0d: got init=%b v=%b want 0 0", c, bus_a.init_done, bus_a.rd_resp_valid); end
    end
    next_cycle(); #2;
    n_cmp++; if (bus_a.init_done !== 1'b1) begin n_err++; $display("FAIL mid_init_rise: got %b want 1", bus_a.init_done); end
    for (int j = 0; j <= 3; j++) begin
      if (j > 0) next_cycle();
      if (j < 3) begin bus_a.rd_req = 4'b0001; bus_a.rd_addr[0] = addrs[j]; end
      else bus_a.rd_req = 4'b0000;
      #2;
      if (j > 0) begin
        n_cmp++; if (bus_a.rd_resp_valid !== 1'b1 || bus_a.rd_resp_data !== 32'h0) begin n_err++; $display("FAIL mid_zero j=%0d: got v=%b %h want v=1 0", j, bus_a.rd_resp_valid, bus_a.rd_resp_data); end
      end
    end
  endtask

  // Instance without zero-fill: RUN on the first cycle out of reset.
  task automatic test_no_clear();
    next_cycle(); #2;
    n_cmp++; if (bus_b.init_done !== 1'b0) begin n_err++; $display("FAIL nc_init_rst: got %b want 0", bus_b.init_done); end
    next_cycle();
    reset_b_n = 1'b1;
    bus_b.wr_req = 4'b0010; bus_b.wr_addr[1] = 4'd3; bus_b.wr_data[1] = 32'hCAFEF00D;
    #2;
    n_cmp++; if (bus_b.init_done !== 1'b1) begin n_err++; $display("FAIL nc_init: got %b want 1", bus_b.init_done); end
    n_cmp++; if (bus_b.wr_grant !== 4'b0010) begin n_err++; $display("FAIL nc_wr_grant: got %b want 0010", bus_b.wr_grant); end
    next_cycle();
    bus_b.wr_req = 4'b0000; bus_b.rd_req = 4'b0001; bus_b.rd_addr[0] = 4'd3;
    #2;
    n_cmp++; if (bus_b.rd_grant !== 4'b0001) begin n_err++; $display("FAIL nc_rd_grant: got %b want 0001", bus_b.rd_grant); end
    n_cmp++; if (bus_b.rd_resp_valid !== 1'b0) begin n_err++; $display("FAIL nc_pre_valid: got %b want 0", bus_b.rd_resp_valid); end
    next_cycle();
    bus_b.rd_req = 4'b0000;
    #2;
    n_cmp++; if (bus_b.rd_resp_valid !== 1'b1 || bus_b.rd_resp_id !== 2'd0) begin n_err++; $display("FAIL nc_resp: got v=%b id=%0d want v=1 id=0", bus_b.rd_resp_valid, bus_b.rd_resp_id); end
    n_cmp++; if (bus_b.rd_resp_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL nc_data: got %h want cafef00d", bus_b.rd_resp_data); end
    next_cycle(); #2;
    n_cmp++; if (bus_b.rd_resp_valid !== 1'b0) begin n_err++; $display("FAIL nc_single: got %b want 0", bus_b.rd_resp_valid); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_read_all();
    test_fairness();
    test_pointer();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid();
    test_no_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
